// File: rtl/htif_burst.sv
// ---------------------------------------------------------------------------
// htif_burst
//   Byte-stream host interface to a word-wide bus, with burst support.
//   The host sends single-byte commands over the rx stream:
//     'a' + ABYTES bytes (LSB first) : load the bus address
//     'n' + 1 byte C                 : set burst length to C+1 words
//     'w' + (C+1)*BPW bytes          : burst write, each word LSB first
//     'r'                            : burst read; each word returned on tx,
//                                      LSB first
//   The address advances by BPW after every accepted bus request and wraps
//   modulo 2^ADDR_W. Only one read is ever in flight on the bus.
//
// Configuration macro:
//   HTIF_ACK_EN - when defined, a completed 'w' burst is acknowledged with
//                 one tx byte 0x2E ('.'). When undefined, writes are silent.
//
// Ports:
//   clock, reset_n        : clock and synchronous active-low reset
//   rx_ready/valid/data   : host-to-bridge byte stream
//   bus_req_*             : bus request channel (held until bus_req_ready)
//   bus_res_valid/data    : read response, one cycle per word
//   tx_ready/valid/data   : bridge-to-host byte stream
//   state                 : current FSM state, debug only
// ---------------------------------------------------------------------------
module htif_burst #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              rx_ready,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              bus_req_ready,
    output logic              bus_req_read,
    output logic              bus_req_write,
    output logic [ADDR_W-1:0] bus_req_address,
    output logic [DATA_W-1:0] bus_req_data,
    input  logic              bus_res_valid,
    input  logic [DATA_W-1:0] bus_res_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic [3:0]        state
);
    localparam int BPW    = DATA_W / 8;
    localparam int ABYTES = ADDR_W / 8;

    localparam logic [7:0]        LAST_WBYTE = 8'(BPW - 1);
    localparam logic [7:0]        LAST_ABYTE = 8'(ABYTES - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BPW);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        ADDR  = 4'd1,
        COUNT = 4'd2,
        WDATA = 4'd3,
        WREQ  = 4'd4,
        RREQ  = 4'd5,
        RWAIT = 4'd6,
        RSEND = 4'd7,
        ACK   = 4'd8
    } state_t;

    state_t            state_q,    state_d;
    logic              rx_ready_q, rx_ready_d;
    logic              rd_q,       rd_d;
    logic              wr_q,       wr_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [ADDR_W-1:0] aasm_q,     aasm_d;     // address being assembled
    logic [DATA_W-1:0] wasm_q,     wasm_d;     // write word being assembled
    logic [DATA_W-1:0] rdata_q,    rdata_d;    // captured read word
    logic [7:0]        byte_q,     byte_d;     // byte index within a field
    logic [7:0]        len_q,      len_d;      // burst length minus one
    logic [7:0]        cnt_q,      cnt_d;      // words remaining minus one
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q,  tx_data_d;

    logic       rx_go;
    logic       tx_go;
    logic [7:0] byte_nx;

    assign rx_go   = rx_ready_q & rx_valid;
    assign tx_go   = tx_valid_q & tx_ready;
    assign byte_nx = byte_q + 8'd1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rx_ready_q <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            aasm_q     <= '0;
            wasm_q     <= '0;
            rdata_q    <= '0;
            byte_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            aasm_q     <= aasm_d;
            wasm_q     <= wasm_d;
            rdata_q    <= rdata_d;
            byte_q     <= byte_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        aasm_d     = aasm_q;
        wasm_d     = wasm_q;
        rdata_d    = rdata_q;
        byte_d     = byte_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;

        case (state_q)
            IDLE: begin
                if (rx_go) begin
                    byte_d = '0;
                    case (rx_data)
                        8'h61: state_d = ADDR;   // 'a'
                        8'h6E: state_d = COUNT;  // 'n'
                        8'h77: begin             // 'w'
                            state_d = WDATA;
                            cnt_d   = len_q;
                        end
                        8'h72: begin             // 'r'
                            state_d = RREQ;
                            cnt_d   = len_q;
                            rd_d    = 1'b1;
                        end
                        default: ;               // unknown byte: dropped
                    endcase
                end
            end

            ADDR: begin
                if (rx_go) begin
                    aasm_d[{byte_q, 3'b000} +: 8] = rx_data;
                    byte_d = byte_nx;
                    if (byte_q == LAST_ABYTE) begin
                        addr_d  = aasm_d;
                        byte_d  = '0;
                        state_d = IDLE;
                    end
                end
            end

            COUNT: begin
                if (rx_go) begin
                    len_d   = rx_data;
                    state_d = IDLE;
                end
            end

            WDATA: begin
                if (rx_go) begin
                    wasm_d[{byte_q, 3'b000} +: 8] = rx_data;
                    byte_d = byte_nx;
                    if (byte_q == LAST_WBYTE) begin
                        wdata_d = wasm_d;
                        wr_d    = 1'b1;
                        byte_d  = '0;
                        state_d = WREQ;
                    end
                end
            end

            WREQ: begin
                if (bus_req_ready) begin
                    wr_d   = 1'b0;
                    addr_d = addr_q + ADDR_STEP;
                    if (cnt_q != 8'd0) begin
                        cnt_d   = cnt_q - 8'd1;
                        state_d = WDATA;
                    end else begin
`ifdef HTIF_ACK_EN
                        tx_valid_d = 1'b1;
                        tx_data_d  = 8'h2E;
                        state_d    = ACK;
`else
                        state_d    = IDLE;
`endif
                    end
                end
            end

            RREQ: begin
                if (bus_req_ready) begin
                    rd_d    = 1'b0;
                    addr_d  = addr_q + ADDR_STEP;
                    state_d = RWAIT;
                end
            end

            RWAIT: begin
                if (bus_res_valid) begin
                    rdata_d    = bus_res_data;
                    tx_valid_d = 1'b1;
                    tx_data_d  = bus_res_data[7:0];
                    byte_d     = '0;
                    state_d    = RSEND;
                end
            end

            RSEND: begin
                // byte_q indexes the byte currently on tx_data
                if (tx_go) begin
                    if (byte_q == LAST_WBYTE) begin
                        tx_valid_d = 1'b0;
                        byte_d     = '0;
                        if (cnt_q != 8'd0) begin
                            cnt_d   = cnt_q - 8'd1;
                            rd_d    = 1'b1;
                            state_d = RREQ;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        byte_d    = byte_nx;
                        tx_data_d = rdata_q[{byte_nx, 3'b000} +: 8];
                    end
                end
            end

            ACK: begin
                if (tx_go) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // registered so that rx_ready stays low through reset and rises on
        // the first clock after release
        rx_ready_d = (state_d == IDLE) || (state_d == ADDR) ||
                     (state_d == COUNT) || (state_d == WDATA);
    end

    assign rx_ready        = rx_ready_q;
    assign bus_req_read    = rd_q;
    assign bus_req_write   = wr_q;
    assign bus_req_address = addr_q;
    assign bus_req_data    = wdata_q;
    assign tx_valid        = tx_valid_q;
    assign tx_data         = tx_data_q;
    assign state           = state_q;

endmodule

// File: tb/tb_htif_burst.sv
`timescale 1ns/1ps
// Testbench for htif_burst: a 32-bit and a 64-bit instance share stimulus;
// the one not selected is held in reset. Expected bus writes, bus reads and
// tx bytes are queued by the stimulus and checked by an independent monitor.
module tb_htif_burst;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel64;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        bus_req_ready;
    logic        bus_res_valid;
    logic [63:0] bus_res_data;
    logic        tx_ready;

    logic        reset32_n, reset64_n;
    assign reset32_n = rst_n & ~sel64;
    assign reset64_n = rst_n & sel64;

    logic        rx_ready32, rd32, wr32, txv32;
    logic [31:0] addr32, wdata32;
    logic [7:0]  txd32;
    logic [3:0]  st32;
    logic        rx_ready64, rd64, wr64, txv64;
    logic [31:0] addr64;
    logic [63:0] wdata64;
    logic [7:0]  txd64;
    logic [3:0]  st64;

    htif_burst #(.DATA_W(32), .ADDR_W(32)) dut32 (
        .clock(clk), .reset_n(reset32_n),
        .rx_ready(rx_ready32), .rx_valid(rx_valid), .rx_data(rx_data),
        .bus_req_ready(bus_req_ready), .bus_req_read(rd32), .bus_req_write(wr32),
        .bus_req_address(addr32), .bus_req_data(wdata32),
        .bus_res_valid(bus_res_valid), .bus_res_data(bus_res_data[31:0]),
        .tx_ready(tx_ready), .tx_valid(txv32), .tx_data(txd32), .state(st32)
    );

    htif_burst #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clock(clk), .reset_n(reset64_n),
        .rx_ready(rx_ready64), .rx_valid(rx_valid), .rx_data(rx_data),
        .bus_req_ready(bus_req_ready), .bus_req_read(rd64), .bus_req_write(wr64),
        .bus_req_address(addr64), .bus_req_data(wdata64),
        .bus_res_valid(bus_res_valid), .bus_res_data(bus_res_data),
        .tx_ready(tx_ready), .tx_valid(txv64), .tx_data(txd64), .state(st64)
    );

    logic        m_rx_ready, m_read, m_write, m_tx_valid;
    logic [31:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_tx_data;
    logic [3:0]  m_state;
    assign m_rx_ready = sel64 ? rx_ready64 : rx_ready32;
    assign m_read     = sel64 ? rd64 : rd32;
    assign m_write    = sel64 ? wr64 : wr32;
    assign m_tx_valid = sel64 ? txv64 : txv32;
    assign m_addr     = sel64 ? addr64 : addr32;
    assign m_wdata    = sel64 ? wdata64 : {32'd0, wdata32};
    assign m_tx_data  = sel64 ? txd64 : txd32;
    assign m_state    = sel64 ? st64 : st32;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [7:0]  exp_tx[$];
    logic [63:0] resp_q[$];

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int tx_cnt = 0;
    int resp_delay = 0;
    bit outstanding = 1'b0;
    bit tx_toggle = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: handshakes seen at the negedge complete on the next posedge.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (m_write && bus_req_ready) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: got write 0x%0h @0x%0h, expected none", m_wdata, m_addr);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 64'(m_addr), 64'(e.addr));
                    check("wr_data", m_wdata, e.data);
                    $display("[TB] write @0x%08h data 0x%0h", m_addr, m_wdata);
                end
            end
            if (m_read && bus_req_ready) begin
                rd_cnt++;
                check("one_outstanding", 64'(outstanding), 64'd0);
                outstanding = 1'b1;
                resp_delay  = 3;
                if (exp_rd.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_read: got read @0x%0h, expected none", m_addr);
                end else begin
                    check("rd_addr", 64'(m_addr), 64'(exp_rd.pop_front()));
                    $display("[TB] read  @0x%08h", m_addr);
                end
            end
            if (m_tx_valid && tx_ready) begin
                tx_cnt++;
                if (exp_tx.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_tx: got byte 0x%02h, expected none", m_tx_data);
                end else begin
                    check("tx_byte", 64'(m_tx_data), 64'(exp_tx.pop_front()));
                    $display("[TB] tx    0x%02h", m_tx_data);
                end
            end
        end
    end

    // Bus responder: one-cycle response a few cycles after each read.
    initial begin
        bus_res_valid = 1'b0;
        bus_res_data  = '0;
        forever begin
            @(posedge clk); #1;
            bus_res_valid = 1'b0;
            if (resp_delay > 0) begin
                resp_delay--;
                if (resp_delay == 0) begin
                    bus_res_valid = 1'b1;
                    bus_res_data  = (resp_q.size() != 0) ? resp_q.pop_front() : 64'd0;
                    outstanding   = 1'b0;
                end
            end
        end
    end

    // tx_ready driver: constant high, or alternating when tx_toggle is set.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            tx_ready = tx_toggle ? ~tx_ready : 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!ok && n < 300) begin
            @(negedge clk);
            ok = m_rx_ready;
            @(posedge clk); #1;
            n++;
        end
        rx_valid = 1'b0;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL rx_accept: byte 0x%02h not accepted, required within 300 cycles", b);
        end
    endtask

    task automatic set_addr(input logic [31:0] a);
        send_byte(8'h61);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    endtask

    task automatic set_len(input logic [7:0] c);
        send_byte(8'h6E);
        send_byte(c);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        int n;
        done = 1'b0;
        n    = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            done = (exp_wr.size() == 0) && (exp_rd.size() == 0) && (exp_tx.size() == 0) &&
                   (m_state == 4'd0) && !m_tx_valid && (resp_delay == 0);
            n++;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s: not idle after 2000 cycles, still expecting %0d writes %0d reads %0d bytes",
                     name, exp_wr.size(), exp_rd.size(), exp_tx.size());
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        bit quiet;
        rst_n         = 1'b0;
        sel64         = 1'b0;
        rx_valid      = 1'b0;
        rx_data       = 8'h00;
        bus_req_ready = 1'b1;

        // ---- reset values ----
        tick(3);
        @(negedge clk);
        check("rst_state",    64'(m_state),    64'd0);
        check("rst_rx_ready", 64'(m_rx_ready), 64'd0);
        check("rst_read",     64'(m_read),     64'd0);
        check("rst_write",    64'(m_write),    64'd0);
        check("rst_addr",     64'(m_addr),     64'd0);
        check("rst_wdata",    m_wdata,         64'd0);
        check("rst_tx_valid", 64'(m_tx_valid), 64'd0);
        check("rst_tx_data",  64'(m_tx_data),  64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rx_ready_after_reset", 64'(m_rx_ready), 64'd1);
        tick(1);

        // ---- two-word write burst ----
        set_addr(32'h0000_1000);
        set_len(8'h01);
        exp_wr.push_back('{addr: 32'h0000_1000, data: 64'h4433_2211});
        exp_wr.push_back('{addr: 32'h0000_1004, data: 64'h8877_6655});
`ifdef HTIF_ACK_EN
        exp_tx.push_back(8'h2E);
`endif
        c0 = wr_cnt;
        send_byte(8'h77);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h11 * (i + 1)));
        wait_idle("t1_idle");
        check("t1_write_count", 64'(wr_cnt - c0), 64'd2);
        check("t1_final_addr",  64'(m_addr),      64'h1008);
        tick(1);

        // ---- write held by bus_req_ready low for 5 cycles ----
        set_addr(32'h0000_3000);
        set_len(8'h00);
        bus_req_ready = 1'b0;
        exp_wr.push_back('{addr: 32'h0000_3000, data: 64'hDDCC_BBAA});
`ifdef HTIF_ACK_EN
        exp_tx.push_back(8'h2E);
`endif
        c0 = wr_cnt;
        send_byte(8'h77);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_hold_write", 64'(m_write), 64'd1);
            check("t2_hold_addr",  64'(m_addr),  64'h3000);
            check("t2_hold_data",  m_wdata,      64'hDDCC_BBAA);
        end
        @(posedge clk); #1;
        bus_req_ready = 1'b1;
        wait_idle("t2_idle");
        check("t2_write_count", 64'(wr_cnt - c0), 64'd1);
        check("t2_final_addr",  64'(m_addr),      64'h3004);
        tick(1);

        // ---- 3-word read with tx_ready toggling ----
        set_addr(32'h0000_4000);
        set_len(8'h02);
        for (int w = 0; w < 3; w++) begin
            resp_q.push_back(64'(32'hA3A2_A1A0 + 32'h1010_1010 * w));
            exp_rd.push_back(32'h4000 + 32'(4 * w));
            for (int b = 0; b < 4; b++) exp_tx.push_back(8'(8'hA0 + 16 * w + b));
        end
        c0 = rd_cnt;
        tx_toggle = 1'b1;
        send_byte(8'h72);
        wait_idle("t3_idle");
        tx_toggle = 1'b0;
        check("t3_read_count", 64'(rd_cnt - c0), 64'd3);
        check("t3_final_addr", 64'(m_addr),      64'h400C);
        tick(2);

        // ---- address wrap ----
        set_addr(32'hFFFF_FFFC);
        set_len(8'h01);
        exp_wr.push_back('{addr: 32'hFFFF_FFFC, data: 64'h0403_0201});
        exp_wr.push_back('{addr: 32'h0000_0000, data: 64'h0807_0605});
`ifdef HTIF_ACK_EN
        exp_tx.push_back(8'h2E);
`endif
        send_byte(8'h77);
        for (int i = 0; i < 8; i++) send_byte(8'(i + 1));
        wait_idle("t4_idle");
        check("t4_final_addr", 64'(m_addr), 64'h4);
        tick(1);

        // ---- reset during the 2nd word of a 4-word read ----
        set_addr(32'h0000_5000);
        set_len(8'h03);
        resp_q.push_back(64'h1312_1110);
        resp_q.push_back(64'h2322_2120);
        exp_rd.push_back(32'h5000);
        for (int b = 0; b < 4; b++) exp_tx.push_back(8'(8'h10 + b));
        exp_rd.push_back(32'h5004);
        c0 = rd_cnt;
        send_byte(8'h72);
        begin
            int n;
            n = 0;
            while (rd_cnt < c0 + 2 && n < 500) begin
                @(negedge clk);
                n++;
            end
            check("t5_second_read_seen", 64'(rd_cnt - c0), 64'd2);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        tick(2);
        @(negedge clk);
        check("t5_rst_state",    64'(m_state),    64'd0);
        check("t5_rst_rx_ready", 64'(m_rx_ready), 64'd0);
        check("t5_rst_read",     64'(m_read),     64'd0);
        check("t5_rst_tx_valid", 64'(m_tx_valid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_rx_ready_release", 64'(m_rx_ready), 64'd1);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_read || m_tx_valid) quiet = 1'b0;
        end
        check("t5_quiet_after_reset", 64'(quiet), 64'd1);
        check("t5_addr_after_reset",  64'(m_addr), 64'd0);
        tick(1);
        // len back to 0: a read is a single word
        resp_q.push_back(64'h3332_3130);
        exp_rd.push_back(32'h0);
        for (int b = 0; b < 4; b++) exp_tx.push_back(8'(8'h30 + b));
        c0 = rd_cnt;
        send_byte(8'h72);
        wait_idle("t5_idle");
        check("t5_default_len_reads", 64'(rd_cnt - c0), 64'd1);
        check("t5_final_addr",        64'(m_addr),      64'h4);
`ifdef HTIF_ACK_EN
        tick(1);
        exp_wr.push_back('{addr: 32'h0000_0004, data: 64'h4443_4241});
        exp_tx.push_back(8'h2E);
        send_byte(8'h77);
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h43); send_byte(8'h44);
        wait_idle("t5_ack_idle");
`endif
        tick(1);

        // ---- 64-bit instance: single-word read ----
        sel64 = 1'b1;
        tick(2);
        set_addr(32'h0000_2000);
        resp_q.push_back(64'h0807_0605_0403_0201);
        exp_rd.push_back(32'h2000);
        for (int b = 0; b < 8; b++) exp_tx.push_back(8'(b + 1));
        c0 = tx_cnt;
        send_byte(8'h72);
        wait_idle("t6_idle");
        check("t6_tx_count",   64'(tx_cnt - c0), 64'd8);
        check("t6_final_addr", 64'(m_addr),      64'h2008);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
